// File: rtl/fa_bist.sv
// Self-test controller for the one-bit full adder: sweeps all eight {a,b,c}
// vectors, checks sum/carry against golden values and records the outcome.
module fa_bist #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       sum,
  input  logic       carry,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_count,
  output logic [2:0] first_fail_vec,
  output logic       first_fail_valid
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

  state_t     state;
  logic [2:0] vec;
  logic [3:0] cnt;
  logic       exp_sum;
  logic       exp_carry;
  logic       mismatch;
  logic [3:0] fail_count_nxt;

  assign {a, b, c} = vec;

  // Golden response for the vector currently on the adder inputs.
  always_comb begin
    exp_sum        = vec[2] ^ vec[1] ^ vec[0];
    exp_carry      = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
    mismatch       = (sum != exp_sum) || (carry != exp_carry);
    fail_count_nxt = fail_count + {3'b000, mismatch};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      vec              <= 3'd0;
      cnt              <= 4'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_count       <= 4'd0;
      first_fail_vec   <= 3'd0;
      first_fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state            <= RUN;
            vec              <= 3'd0;
            cnt              <= 4'd0;
            busy             <= 1'b1;
            pass             <= 1'b0;
            fail_count       <= 4'd0;
            first_fail_vec   <= 3'd0;
            first_fail_valid <= 1'b0;
          end
        end
        RUN: begin
          if (cnt != LAST_CNT) begin
            cnt <= cnt + 4'd1;
          end else begin
            fail_count <= fail_count_nxt;
            if (mismatch && !first_fail_valid) begin
              first_fail_vec   <= vec;
              first_fail_valid <= 1'b1;
            end
            cnt <= 4'd0;
            if (vec != 3'd7) begin
              vec <= vec + 3'd1;
            end else begin
              // pass uses the updated count so the last vector's result counts
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              vec   <= 3'd0;
              pass  <= (fail_count_nxt == 4'd0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fa_bist.sv
// Bench for fa_bist: a model adder with selectable faults drives one SETTLE=2
// instance, an ideal adder drives a SETTLE=1 instance for stimulus ordering.
module tb_fa_bist;

  typedef struct {
    logic [1:0] mode;
    logic       expPass;
    logic [3:0] expCount;
    logic [2:0] expVec;
    logic       expValid;
  } sweep_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN;
  logic       start2, start1;
  logic       a2, b2, c2, sum2, carry2, busy2, done2, pass2, firstValid2;
  logic [3:0] failCount2;
  logic [2:0] firstVec2;
  logic       a1, b1, c1, sum1, carry1, busy1, done1, pass1, firstValid1;
  logic [3:0] failCount1;
  logic [2:0] firstVec1;
  logic [1:0] mode;

  int checks = 0;
  int failures = 0;
  sweep_t table_[6];
  sweep_t expQ[$];

  fa_bist #(.SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rstN), .start(start2), .a(a2), .b(b2), .c(c2),
    .sum(sum2), .carry(carry2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_count(failCount2), .first_fail_vec(firstVec2), .first_fail_valid(firstValid2)
  );

  fa_bist #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rstN), .start(start1), .a(a1), .b(b1), .c(c1),
    .sum(sum1), .carry(carry1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_count(failCount1), .first_fail_vec(firstVec1), .first_fail_valid(firstValid1)
  );

  // Mode 0 ideal, 1 carry stuck-at-0, 2 sum inverted, 3 sum stuck-at-0.
  always_comb begin
    sum2   = a2 ^ b2 ^ c2;
    carry2 = (a2 & b2) | (a2 & c2) | (b2 & c2);
    case (mode)
      2'd1: carry2 = 1'b0;
      2'd2: sum2 = ~(a2 ^ b2 ^ c2);
      2'd3: sum2 = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    sum1   = a1 ^ b1 ^ c1;
    carry1 = (a1 & b1) | (a1 & c1) | (b1 & c1);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    start2 = 1'b1;
  endtask

  // Counts negedges after the start edge until done; start drops after the first edge unless kept.
  task automatic waitDone(input bit keepStart, output int n, output int busyCnt);
    n = 0;
    busyCnt = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (!keepStart) start2 = 1'b0;
      if (busy2) busyCnt++;
      if (done2) break;
    end
  endtask

  task automatic checkSweep(input string tag);
    sweep_t e;
    if (expQ.size() == 0) begin
      checkOutput({tag, "_queue"}, 32'd0, 32'd1);
      return;
    end
    e = expQ.pop_front();
    checkOutput({tag, "_pass"}, 32'(pass2), 32'(e.expPass));
    checkOutput({tag, "_count"}, 32'(failCount2), 32'(e.expCount));
    checkOutput({tag, "_vec"}, 32'(firstVec2), 32'(e.expVec));
    checkOutput({tag, "_valid"}, 32'(firstValid2), 32'(e.expValid));
  endtask

  initial begin
    int n, busyCnt;
    table_[0] = '{2'd0, 1'b1, 4'd0, 3'd0, 1'b0};
    table_[1] = '{2'd1, 1'b0, 4'd4, 3'd3, 1'b1};
    table_[2] = '{2'd2, 1'b0, 4'd8, 3'd0, 1'b1};
    table_[3] = '{2'd0, 1'b1, 4'd0, 3'd0, 1'b0};
    table_[4] = '{2'd3, 1'b0, 4'd4, 3'd1, 1'b1};
    table_[5] = '{2'd0, 1'b1, 4'd0, 3'd0, 1'b0};

    rstN = 1'b0; start2 = 1'b0; start1 = 1'b0; mode = 2'd0;
    #1;
    checkOutput("reset_state", {a2, b2, c2, busy2, done2, pass2, failCount2, firstVec2, firstValid2}, 32'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    foreach (table_[i]) begin
      mode = table_[i].mode;
      expQ.push_back(table_[i]);
      applyStimulus();
      waitDone(1'b0, n, busyCnt);
      checkOutput($sformatf("t%0d_latency", i), 32'(n), 32'd17);
      checkOutput($sformatf("t%0d_busy", i), 32'(busyCnt), 32'd16);
      checkSweep($sformatf("t%0d", i));
      if (i == 1) begin
        repeat (3) @(negedge clk);
        checkOutput("hold_count", 32'(failCount2), 32'd4);
        checkOutput("hold_done", 32'(done2), 32'd0);
        checkOutput("hold_vec", 32'(firstVec2), 32'd3);
      end
    end

    // SETTLE=1: one vector per cycle, extra start pulses while busy are ignored.
    @(negedge clk);
    start1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start1 = (k == 3 || k == 5) ? 1'b1 : 1'b0;
      checkOutput($sformatf("order_%0d", k), 32'({a1, b1, c1}), 32'(k - 1));
      checkOutput($sformatf("order_busy_%0d", k), 32'(busy1), 32'd1);
    end
    @(negedge clk);
    checkOutput("s1_done", 32'(done1), 32'd1);
    checkOutput("s1_pass", 32'(pass1), 32'd1);
    checkOutput("s1_count", 32'(failCount1), 32'd0);
    checkOutput("s1_abc_idle", 32'({a1, b1, c1}), 32'd0);
    @(negedge clk);
    checkOutput("s1_done_pulse", 32'(done1), 32'd0);
    checkOutput("s1_no_restart", 32'(busy1), 32'd0);

    // Reset in the middle of a failing sweep.
    mode = 2'd2;
    applyStimulus();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start2 = 1'b0;
    end
    checkOutput("mid_count", 32'(failCount2), 32'd2);
    checkOutput("mid_busy", 32'(busy2), 32'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("rst_async", {a2, b2, c2, busy2, done2, pass2, failCount2, firstVec2, firstValid2}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    mode = 2'd0;
    expQ.push_back(table_[0]);
    applyStimulus();
    waitDone(1'b0, n, busyCnt);
    checkOutput("post_rst_latency", 32'(n), 32'd17);
    checkSweep("post_rst");

    // start held high: back-to-back sweeps, each starting in the done cycle.
    mode = 2'd2;
    expQ.push_back(table_[2]);
    applyStimulus();
    waitDone(1'b1, n, busyCnt);
    checkOutput("b2b0_latency", 32'(n), 32'd17);
    checkSweep("b2b0");
    mode = 2'd0;
    expQ.push_back(table_[0]);
    waitDone(1'b0, n, busyCnt);
    checkOutput("b2b1_latency", 32'(n), 32'd17);
    checkOutput("b2b1_busy", 32'(busyCnt), 32'd16);
    checkSweep("b2b1");
    repeat (2) @(negedge clk);
    checkOutput("b2b_stop", 32'(busy2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
